dircc_avalon_st_packet_source: RTL and testbench

Avalon-ST source that emits test packets under control of a small Avalon-MM register slave. It is the transmitting end for stream sinks in the DiRCC FPGA test fabric. It drives packet framing (startofpacket, endofpacket, empty), honours sink backpressure, and reports progress through a status register. Typical use: feed a processing element under test, or loop back into a stream terminal.

---
 rtl/dircc_avalon_st_pkg.sv | 28 ++
 rtl/dircc_avalon_st_source_regs.sv | 85 ++++++++
 rtl/dircc_avalon_st_packet_source.sv | 187 ++++++++++++++++++
 tb/tb_dircc_avalon_st_packet_source.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dircc_avalon_st_pkg.sv
// Shared definitions for the DiRCC Avalon-ST packet source: register map,
// CONTROL/STATUS field positions and the sender FSM state type.
package dircc_avalon_st_pkg;

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_LENGTH  = 2'd1;
  localparam logic [1:0] ADDR_SEED    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_CONT_BIT  = 1;
  localparam int unsigned CTRL_ABORT_BIT = 2;

  localparam int unsigned STATUS_BUSY_BIT  = 15;
  localparam int unsigned STATUS_TRUNC_BIT = 14;
  localparam int unsigned STATUS_COUNT_W   = 14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  function automatic logic [15:0] status_word(input logic busy, input logic trunc,
                                              input logic [STATUS_COUNT_W-1:0] count);
    status_word = {busy, trunc, count};
  endfunction

endpackage

// File: rtl/dircc_avalon_st_source_regs.sv
// Avalon-MM register file for the packet source: CONTROL/LENGTH/SEED/STATUS
// with registered readdata. ABORT decoding exists only with DIRCC_ST_SOURCE_ABORT_EN.
module dircc_avalon_st_source_regs
  import dircc_avalon_st_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                address,
  input  logic [15:0]               writedata,
  input  logic                      write_n,
  input  logic                      read_n,
  output logic [15:0]               readdata,
  input  logic                      busy,
  input  logic                      trunc,
  input  logic [STATUS_COUNT_W-1:0] count,
  output logic [15:0]               length,
  output logic [15:0]               seed,
  output logic                      cont,
  output logic                      start,
  output logic                      abort,
  output logic                      status_clr
);

  logic [15:0] length_q, length_d;
  logic [15:0] seed_q, seed_d;
  logic [15:0] readdata_q, readdata_d;
  logic        cont_q, cont_d;
  logic        wr_ctrl;

  always_comb begin
    length_d   = length_q;
    seed_d     = seed_q;
    cont_d     = cont_q;
    readdata_d = readdata_q;
    wr_ctrl    = !write_n && (address == ADDR_CONTROL);
    start      = wr_ctrl && writedata[CTRL_START_BIT];
    status_clr = !write_n && (address == ADDR_STATUS);

    if (!write_n) begin
      case (address)
        ADDR_CONTROL: cont_d   = writedata[CTRL_CONT_BIT];
        ADDR_LENGTH:  length_d = writedata;
        ADDR_SEED:    seed_d   = writedata;
        default:      ;
      endcase
    end

`ifdef DIRCC_ST_SOURCE_ABORT_EN
    abort = wr_ctrl && writedata[CTRL_ABORT_BIT];
    // An abort accepted while sending also ends continuous mode.
    if (abort && busy) cont_d = 1'b0;
`else
    abort = 1'b0;
`endif

    if (!read_n) begin
      case (address)
        ADDR_CONTROL: readdata_d = '0;
        ADDR_LENGTH:  readdata_d = length_q;
        ADDR_SEED:    readdata_d = seed_q;
        default:      readdata_d = status_word(busy, trunc, count);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      length_q   <= '0;
      seed_q     <= '0;
      cont_q     <= 1'b0;
      readdata_q <= '0;
    end else begin
      length_q   <= length_d;
      seed_q     <= seed_d;
      cont_q     <= cont_d;
      readdata_q <= readdata_d;
    end
  end

  assign length   = length_q;
  assign seed     = seed_q;
  assign cont     = cont_q;
  assign readdata = readdata_q;

endmodule

// File: rtl/dircc_avalon_st_packet_source.sv
// Avalon-ST test packet source with framing, backpressure and status counting.
// Optional truncation via CONTROL.ABORT when DIRCC_ST_SOURCE_ABORT_EN is defined.
module dircc_avalon_st_packet_source
  import dircc_avalon_st_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned EMPTY_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [DATA_WIDTH-1:0]  data,
  output logic [EMPTY_WIDTH-1:0] empty,
  output logic                   startofpacket,
  output logic                   endofpacket,
  output logic                   valid,
  input  logic                   ready,
  input  logic [1:0]             address,
  input  logic [15:0]            writedata,
  input  logic                   write_n,
  input  logic                   read_n,
  output logic [15:0]            readdata
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned BSH   = $clog2(BYTES);

  logic [15:0] length, seed;
  logic        cont, start, abort, status_clr;

  state_e                    state_q, state_d;
  logic [15:0]               idx_q, idx_d;
  logic [15:0]               last_idx_q, last_idx_d;
  logic [15:0]               seed_sh_q, seed_sh_d;
  logic [EMPTY_WIDTH-1:0]    empty_last_q, empty_last_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [EMPTY_WIDTH-1:0]    empty_q, empty_d;
  logic                      sop_q, sop_d, eop_q, eop_d, valid_q, valid_d;
  logic [STATUS_COUNT_W-1:0] count_q, count_d;
  logic                      trunc_q, trunc_d, trunc_pend_q, trunc_pend_d;

  logic                      accept, abort_evt, load, next_eop;
  logic [15:0]               next_idx, beat_val;
  logic [17:0]               p_beats, p_span;
  logic [15:0]               p_last_idx;
  logic [EMPTY_WIDTH-1:0]    p_empty;

  dircc_avalon_st_source_regs u_regs (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .writedata  (writedata),
    .write_n    (write_n),
    .read_n     (read_n),
    .readdata   (readdata),
    .busy       (state_q == ST_SEND),
    .trunc      (trunc_q),
    .count      (count_q),
    .length     (length),
    .seed       (seed),
    .cont       (cont),
    .start      (start),
    .abort      (abort),
    .status_clr (status_clr)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_idx_d   = last_idx_q;
    seed_sh_d    = seed_sh_q;
    empty_last_d = empty_last_q;
    data_d       = data_q;
    empty_d      = empty_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    valid_d      = valid_q;
    count_d      = count_q;
    trunc_d      = trunc_q;
    trunc_pend_d = trunc_pend_q;
    load         = 1'b0;

    accept     = valid_q && ready;
    abort_evt  = abort && (state_q == ST_SEND);
    next_idx   = idx_q + 16'd1;
    beat_val   = seed_sh_q + next_idx;
    next_eop   = (next_idx == last_idx_q);

    // Packet geometry from the live LENGTH register, captured only on load.
    p_beats    = (18'(length) + 18'(BYTES - 1)) >> BSH;
    p_last_idx = 16'(p_beats - 18'd1);
    p_span     = p_beats << BSH;
    p_empty    = EMPTY_WIDTH'(p_span - 18'(length));

    case (state_q)
      ST_IDLE: load = start && (length != '0);
      ST_SEND: begin
        if (accept && eop_q) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          if (trunc_pend_q) trunc_d = 1'b1;
          trunc_pend_d = 1'b0;
          if (cont && !abort_evt && !trunc_pend_q && (length != '0)) begin
            load = 1'b1;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            empty_d = '0;
          end
        end else begin
          if (accept) begin
            idx_d   = next_idx;
            data_d  = DATA_WIDTH'(beat_val);
            sop_d   = 1'b0;
            eop_d   = next_eop;
            empty_d = next_eop ? empty_last_q : '0;
          end
          // Abort turns whichever beat is presented next (or still stalled) into the last one.
          if (abort_evt) begin
            eop_d        = 1'b1;
            empty_d      = '0;
            trunc_pend_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d      = ST_SEND;
      valid_d      = 1'b1;
      idx_d        = '0;
      seed_sh_d    = seed;
      last_idx_d   = p_last_idx;
      empty_last_d = p_empty;
      data_d       = DATA_WIDTH'(seed);
      sop_d        = 1'b1;
      eop_d        = (p_last_idx == '0);
      empty_d      = (p_last_idx == '0) ? p_empty : '0;
    end

    if (status_clr) begin
      count_d = '0;
      trunc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      last_idx_q   <= '0;
      seed_sh_q    <= '0;
      empty_last_q <= '0;
      data_q       <= '0;
      empty_q      <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      valid_q      <= 1'b0;
      count_q      <= '0;
      trunc_q      <= 1'b0;
      trunc_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_idx_q   <= last_idx_d;
      seed_sh_q    <= seed_sh_d;
      empty_last_q <= empty_last_d;
      data_q       <= data_d;
      empty_q      <= empty_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      trunc_q      <= trunc_d;
      trunc_pend_q <= trunc_pend_d;
    end
  end

  assign data          = data_q;
  assign empty         = empty_q;
  assign startofpacket = sop_q;
  assign endofpacket   = eop_q;
  assign valid         = valid_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_source.sv
// Directed bench for dircc_avalon_st_packet_source: expected beats are queued when
// a packet is launched and checked against the stream on every presented cycle.
module tb_dircc_avalon_st_packet_source;
  import dircc_avalon_st_pkg::*;

  localparam int DW = 32;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data;
  logic [EW-1:0] empty;
  logic          startofpacket, endofpacket, valid, ready;
  logic [1:0]    address;
  logic [15:0]   writedata, readdata, rd;
  logic          write_n, read_n;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t sb[$];
  int    total = 0;
  int    bad   = 0;
  logic  hold_chk = 1'b1;

  always #5 clk = ~clk;

  dircc_avalon_st_packet_source #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .data          (data),
    .empty         (empty),
    .startofpacket (startofpacket),
    .endofpacket   (endofpacket),
    .valid         (valid),
    .ready         (ready),
    .address       (address),
    .writedata     (writedata),
    .write_n       (write_n),
    .read_n        (read_n),
    .readdata      (readdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [15:0] v, input logic sop, input logic eop,
                           input logic [EW-1:0] emp);
    beat_t b;
    b.data  = 32'(v);
    b.sop   = sop;
    b.eop   = eop;
    b.empty = emp;
    sb.push_back(b);
  endtask

  task automatic push_pkt(input int len, input int seed);
    int n;
    n = (len + 3) / 4;
    for (int i = 0; i < n; i++)
      push_beat(16'(seed + i), i == 0, i == n - 1, (i == n - 1) ? EW'(n * 4 - len) : '0);
  endtask

  task automatic mm_write(input logic [1:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; write_n = 1'b0;
    @(posedge clk); #1;
    write_n = 1'b1;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [15:0] d);
    @(posedge clk); #1;
    address = a; read_n = 1'b0;
    @(posedge clk); #1;
    read_n = 1'b1;
    d = readdata;
  endtask

  // toggle=1 drives ready low one cycle in three; otherwise ready is held high.
  task automatic wait_drain(input bit toggle, input int budget);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
      ready = toggle ? (k % 3 != 0) : 1'b1;
    end
    check("drained", 32'(sb.size()), 32'd0);
  endtask

  // Every presented beat must match the queue head, stalled or not.
  always @(negedge clk) begin
    if (reset_n && valid && (ready || hold_chk)) begin
      check("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        check("beat_data", data, sb[0].data);
        check("beat_sop", 32'(startofpacket), 32'(sb[0].sop));
        check("beat_eop", 32'(endofpacket), 32'(sb[0].eop));
        check("beat_empty", 32'(empty), 32'(sb[0].empty));
        if (ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    reset_n = 1'b0; ready = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = '0; writedata = '0;
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", data, 32'd0);
    check("rst_sop_eop", 32'({startofpacket, endofpacket}), 32'd0);
    check("rst_empty", 32'(empty), 32'd0);
    check("rst_readdata", 32'(readdata), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic 3-beat packet, no backpressure.
    ready = 1'b1;
    mm_write(ADDR_LENGTH, 16'd10);
    mm_write(ADDR_SEED, 16'h0100);
    push_pkt(10, 16'h0100);
    mm_write(ADDR_CONTROL, 16'h0001);
    check("valid_after_start", 32'(valid), 32'd1);
    wait_drain(1'b0, 20);
    check("idle_after_pkt1", 32'(valid), 32'd0);
    mm_read(ADDR_STATUS, rd);
    check("status_pkt1", 32'(rd), 32'h0001);

    // Same packet under a 1-low/2-high ready pattern.
    ready = 1'b0;
    push_pkt(10, 16'h0100);
    mm_write(ADDR_CONTROL, 16'h0001);
    check("valid_stalled_start", 32'(valid), 32'd1);
    wait_drain(1'b1, 40);
    mm_read(ADDR_STATUS, rd);
    check("status_pkt2", 32'(rd), 32'h0002);

    // Continuous single-beat packets; SEED written mid-run only affects later packets.
    mm_write(ADDR_STATUS, 16'h0000);
    mm_read(ADDR_STATUS, rd);
    check("status_cleared", 32'(rd), 32'h0000);
    mm_write(ADDR_LENGTH, 16'd4);
    mm_write(ADDR_SEED, 16'h0AB0);
    for (int i = 0; i < 5; i++) push_beat(16'h0AB0, 1'b1, 1'b1, '0);
    ready = 1'b0;
    mm_write(ADDR_CONTROL, 16'h0003);
    ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 ready = 1'b0;
    check("cont_back_to_back", 32'(sb.size()), 32'd1);
    mm_write(ADDR_SEED, 16'h0CC0);
    mm_write(ADDR_CONTROL, 16'h0000);
    wait_drain(1'b0, 20);
    check("cont_idle", 32'(valid), 32'd0);
    mm_read(ADDR_STATUS, rd);
    check("status_cont", 32'(rd), 32'h0005);

    // START with LENGTH=0 is ignored.
    mm_write(ADDR_STATUS, 16'h0000);
    mm_write(ADDR_LENGTH, 16'd0);
    mm_write(ADDR_CONTROL, 16'h0001);
    check("len0_no_valid", 32'(valid), 32'd0);
    mm_read(ADDR_STATUS, rd);
    check("status_len0", 32'(rd), 32'h0000);

    // START during SEND does not restart; BUSY visible while stalled.
    mm_write(ADDR_LENGTH, 16'd8);
    mm_write(ADDR_SEED, 16'h0010);
    ready = 1'b0;
    push_pkt(8, 16'h0010);
    mm_write(ADDR_CONTROL, 16'h0001);
    mm_read(ADDR_STATUS, rd);
    check("status_busy", 32'(rd), 32'h8000);
    mm_write(ADDR_CONTROL, 16'h0001);
    mm_write(ADDR_LENGTH, 16'd20);
`ifndef DIRCC_ST_SOURCE_ABORT_EN
    mm_write(ADDR_CONTROL, 16'h0004);
`endif
    wait_drain(1'b1, 40);
    mm_read(ADDR_STATUS, rd);
    check("status_restart_ignored", 32'(rd), 32'h0001);

    // Reset mid-packet after beat 1 is accepted.
    mm_write(ADDR_LENGTH, 16'd12);
    mm_write(ADDR_SEED, 16'h0200);
    push_pkt(12, 16'h0200);
    mm_write(ADDR_CONTROL, 16'h0001);
    ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 ready = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_data", data, 32'd0);
    check("midrst_sop_eop", 32'({startofpacket, endofpacket}), 32'd0);
    check("midrst_readdata", 32'(readdata), 32'd0);
    sb.delete();
    @(posedge clk); #1 reset_n = 1'b1;
    mm_read(ADDR_STATUS, rd);
    check("status_after_rst", 32'(rd), 32'h0000);
    mm_read(ADDR_LENGTH, rd);
    check("length_after_rst", 32'(rd), 32'h0000);
    check("valid_after_rst", 32'(valid), 32'd0);

    // Last-beat acceptance coinciding with a STATUS write: clear wins.
    mm_write(ADDR_LENGTH, 16'd4);
    mm_write(ADDR_SEED, 16'h0055);
    push_pkt(4, 16'h0055);
    mm_write(ADDR_CONTROL, 16'h0001);
    ready = 1'b1; address = ADDR_STATUS; writedata = '0; write_n = 1'b0;
    @(posedge clk); #1;
    write_n = 1'b1; ready = 1'b0;
    check("clear_race_drained", 32'(sb.size()), 32'd0);
    mm_read(ADDR_STATUS, rd);
    check("status_clear_wins", 32'(rd), 32'h0000);

`ifdef DIRCC_ST_SOURCE_ABORT_EN
    // Abort after beat 2: stalled beat 3 becomes the truncated last beat.
    mm_write(ADDR_LENGTH, 16'd40);
    mm_write(ADDR_SEED, 16'h0300);
    for (int i = 0; i < 3; i++) push_beat(16'(16'h0300 + i), i == 0, 1'b0, '0);
    mm_write(ADDR_CONTROL, 16'h0001);
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ready = 1'b0;
    hold_chk = 1'b0;
    check("abort_pre_drained", 32'(sb.size()), 32'd0);
    mm_write(ADDR_CONTROL, 16'h0004);
    push_beat(16'h0303, 1'b0, 1'b1, '0);
    hold_chk = 1'b1;
    wait_drain(1'b0, 20);
    check("abort_idle", 32'(valid), 32'd0);
    mm_read(ADDR_STATUS, rd);
    check("status_trunc", 32'(rd), 32'h4001);
    mm_write(ADDR_STATUS, 16'h0000);
    mm_read(ADDR_STATUS, rd);
    check("status_trunc_cleared", 32'(rd), 32'h0000);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
